// File: rtl/tap_bus_dispatcher_pkg.sv
// Shared constants and helpers for the TAP-to-bus dispatcher.
// Status codes, bus selects and FSM state encodings.
package tap_bus_dispatcher_pkg;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;

  localparam logic BUS_AHB = 1'b0;
  localparam logic BUS_APB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic pick_done(
    input logic sel,
    input logic done_ahb,
    input logic done_apb
  );
    return (sel == BUS_APB) ? done_apb : done_ahb;
  endfunction

endpackage

// File: rtl/tap_bus_dispatcher_sat_counter.sv
// Saturating up-counter used for the dispatcher statistics.
// Holds at all-ones once reached; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = &r_count;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/tap_bus_dispatcher.sv
// Single-outstanding TAP command dispatcher towards AHB/APB masters.
// Issues one start pulse, waits for done or timeout, returns a response.
module tap_bus_dispatcher
  import tap_bus_dispatcher_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_bus_sel,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              transfer_TAP_AHB,
  output logic              transfer_TAP_APB,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_write,
  input  logic              done_AHB_TAP,
  input  logic              done_APB_TAP,
  input  logic [DATA_W-1:0] rdata_AHB,
  input  logic [DATA_W-1:0] rdata_APB,
  input  logic              timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              stray_done,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  tout_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_sel;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_status;
  logic [DATA_W-1:0] r_rdata;
  logic              r_stray;

  logic              w_sel_done;
  logic              w_oth_done;
  logic              w_any_done;
  logic [DATA_W-1:0] w_sel_rdata;
  logic              w_accept;
  logic              w_in_wait;
  logic              w_hshake;
  logic              w_inc_ok;
  logic              w_inc_to;

  assign w_sel_done  = pick_done(r_sel, done_AHB_TAP, done_APB_TAP);
  assign w_oth_done  = pick_done(~r_sel, done_AHB_TAP, done_APB_TAP);
  assign w_any_done  = done_AHB_TAP | done_APB_TAP;
  assign w_sel_rdata = (r_sel == BUS_APB) ? rdata_APB : rdata_AHB;
  assign w_accept    = (r_state == ST_IDLE) & req_valid;
  assign w_in_wait   = (r_state == ST_WAIT);
  assign w_hshake    = (r_state == ST_RESP) & rsp_ready;
  assign w_inc_ok    = w_hshake & (r_status == STAT_OK);
  assign w_inc_to    = w_hshake & (r_status == STAT_TIMEOUT);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_sel_done || timeout) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sel    <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_status <= STAT_OK;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_sel   <= req_bus_sel;
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Selected done beats a simultaneous timeout.
      if (w_in_wait && w_sel_done) begin
        r_status <= STAT_OK;
        r_rdata  <= r_write ? '0 : w_sel_rdata;
      end else if (w_in_wait && timeout) begin
        r_status <= STAT_TIMEOUT;
        r_rdata  <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_stray <= 1'b0;
    end else if ((w_any_done && !w_in_wait) ||
                 (w_oth_done && w_in_wait)) begin
      r_stray <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_xfer_cnt (
    .sys_clk (sys_clk),
    .rst     (rst),
    .inc     (w_inc_ok),
    .count   (xfer_count)
  );

  sat_counter #(.W(CNT_W)) u_tout_cnt (
    .sys_clk (sys_clk),
    .rst     (rst),
    .inc     (w_inc_to),
    .count   (tout_count)
  );

  assign req_ready        = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign transfer_TAP_AHB = (r_state == ST_ISSUE) & (r_sel == BUS_AHB);
  assign transfer_TAP_APB = (r_state == ST_ISSUE) & (r_sel == BUS_APB);
  assign bus_addr         = r_addr;
  assign bus_wdata        = r_wdata;
  assign bus_write        = r_write;
  assign rsp_valid        = (r_state == ST_RESP);
  assign rsp_status       = r_status;
  assign rsp_rdata        = r_rdata;
  assign stray_done       = r_stray;

endmodule
